// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage feeding the IF/ID register.
// Owns the PC, runs a valid/ready request handshake to instruction memory,
// buffers a returned word across hazard stalls and handles EX redirects,
// including redirects that arrive while a memory request is still waiting.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        stall_in,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] fetch_instr,
    output logic [31:0] fetch_pc,
    output logic        fetch_valid,
    output logic        IF_ID_LE,
    output logic        IF_ID_Reset
);

    // BOOT : idle cycle after reset, no request yet
    // REQ  : request outstanding at pc
    // HOLD : a word was fetched during a stall and is parked in the buffer
    // DROP : request at the old pc must complete, but its word is discarded
    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] redir_pc_q, redir_pc_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pc_q, buf_pc_d;

    logic [31:0] pc_inc;
    logic [31:0] target_aligned;

    // Force a redirect target onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    // Sequential PC wraps modulo 2^32.
    assign pc_inc         = pc_q + 32'(PC_STEP);
    assign target_aligned = word_align(redirect_target);

    // State and datapath registers; reset drops any outstanding request at once.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= S_BOOT;
            pc_q        <= RESET_PC;
            redir_pc_q  <= 32'h0000_0000;
            buf_instr_q <= 32'h0000_0000;
            buf_pc_q    <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            redir_pc_q  <= redir_pc_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
        end
    end

    // Next-state and PC update; redirect outranks stall, stall outranks sequential fetch.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        redir_pc_d  = redir_pc_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        case (state_q)
            S_BOOT: begin
                state_d = S_REQ;
                if (redirect_valid) begin
                    pc_d = target_aligned;
                end
            end
            S_REQ: begin
                if (imem_ready) begin
                    if (redirect_valid) begin
                        // Returned word belongs to the wrong path.
                        pc_d = target_aligned;
                    end else if (!stall_in) begin
                        pc_d = pc_inc;
                    end else begin
                        buf_instr_d = imem_rdata;
                        buf_pc_d    = pc_q;
                        state_d     = S_HOLD;
                    end
                end else if (redirect_valid) begin
                    // Address must stay stable until the pending request completes.
                    redir_pc_d = target_aligned;
                    state_d    = S_DROP;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    pc_d    = target_aligned;
                    state_d = S_REQ;
                end else if (!stall_in) begin
                    pc_d    = pc_inc;
                    state_d = S_REQ;
                end
            end
            S_DROP: begin
                if (redirect_valid) begin
                    redir_pc_d = target_aligned;
                end
                if (imem_ready) begin
                    pc_d    = redirect_valid ? target_aligned : redir_pc_q;
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    // Output decode: request strobe, word presented to IF/ID, and its load enable.
    always_comb begin
        imem_req    = 1'b0;
        fetch_instr = 32'h0000_0000;
        fetch_pc    = pc_q;
        fetch_valid = 1'b0;
        IF_ID_LE    = 1'b0;
        case (state_q)
            S_REQ: begin
                imem_req = 1'b1;
                if (imem_ready && !redirect_valid) begin
                    fetch_instr = imem_rdata;
                    fetch_pc    = pc_q;
                    fetch_valid = 1'b1;
                    IF_ID_LE    = !stall_in;
                end
            end
            S_HOLD: begin
                if (!redirect_valid) begin
                    fetch_instr = buf_instr_q;
                    fetch_pc    = buf_pc_q;
                    fetch_valid = 1'b1;
                    IF_ID_LE    = !stall_in;
                end
            end
            S_DROP: begin
                imem_req = 1'b1;
            end
            default: begin
                imem_req = 1'b0;
            end
        endcase
        if (!Reset) begin
            imem_req    = 1'b0;
            fetch_instr = 32'h0000_0000;
            fetch_pc    = 32'h0000_0000;
            fetch_valid = 1'b0;
            IF_ID_LE    = 1'b0;
        end
    end

    // Flush IF/ID on any redirect and while held in reset; never coincides with LE.
    assign IF_ID_Reset = redirect_valid | ~Reset;
    assign imem_addr   = pc_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed testbench for if_fetch_unit: a cycle table of inputs and
// hand-computed expected outputs, followed by reset-related sequences.
module tb_if_fetch_unit;

    logic        clk;
    logic        Reset;
    logic        stall_in;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] fetch_instr;
    logic [31:0] fetch_pc;
    logic        fetch_valid;
    logic        IF_ID_LE;
    logic        IF_ID_Reset;

    int checks;
    int failures;

    if_fetch_unit #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
        .clk             (clk),
        .Reset           (Reset),
        .stall_in        (stall_in),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rdata      (imem_rdata),
        .fetch_instr     (fetch_instr),
        .fetch_pc        (fetch_pc),
        .fetch_valid     (fetch_valid),
        .IF_ID_LE        (IF_ID_LE),
        .IF_ID_Reset     (IF_ID_Reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        rv;
        logic [31:0] rt;
        logic        rdy;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic        e_valid;
        logic        e_le;
        logic        e_rst;
    } vec_t;

    vec_t vecs[$];

    localparam logic [31:0] D = 32'hDEAD_BEEF;

    function automatic vec_t mk(input logic stall, input logic rv, input logic [31:0] rt,
                                input logic rdy, input logic [31:0] rdata,
                                input logic e_req, input logic [31:0] e_addr,
                                input logic [31:0] e_instr, input logic [31:0] e_pc,
                                input logic e_valid, input logic e_le, input logic e_rst);
        vec_t v;
        v.stall = stall; v.rv = rv; v.rt = rt; v.rdy = rdy; v.rdata = rdata;
        v.e_req = e_req; v.e_addr = e_addr; v.e_instr = e_instr; v.e_pc = e_pc;
        v.e_valid = e_valid; v.e_le = e_le; v.e_rst = e_rst;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs after the falling edge and check outputs 1ns later.
    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        stall_in        = v.stall;
        redirect_valid  = v.rv;
        redirect_target = v.rt;
        imem_ready      = v.rdy;
        imem_rdata      = v.rdata;
        #1;
        chk({tag, ".imem_req"},    32'(imem_req),    32'(v.e_req));
        chk({tag, ".imem_addr"},   imem_addr,        v.e_addr);
        chk({tag, ".fetch_instr"}, fetch_instr,      v.e_instr);
        chk({tag, ".fetch_pc"},    fetch_pc,         v.e_pc);
        chk({tag, ".fetch_valid"}, 32'(fetch_valid), 32'(v.e_valid));
        chk({tag, ".IF_ID_LE"},    32'(IF_ID_LE),    32'(v.e_le));
        chk({tag, ".IF_ID_Reset"}, 32'(IF_ID_Reset), 32'(v.e_rst));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".imem_req"},    32'(imem_req),    32'd0);
        chk({tag, ".IF_ID_LE"},    32'(IF_ID_LE),    32'd0);
        chk({tag, ".fetch_valid"}, 32'(fetch_valid), 32'd0);
        chk({tag, ".fetch_instr"}, fetch_instr,      32'd0);
        chk({tag, ".fetch_pc"},    fetch_pc,         32'd0);
        chk({tag, ".IF_ID_Reset"}, 32'(IF_ID_Reset), 32'd1);
        chk({tag, ".imem_addr"},   imem_addr,        32'd0);
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        Reset           = 1'b0;
        stall_in        = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'd0;
        imem_ready      = 1'b0;
        imem_rdata      = 32'd0;

        //          stall rv rt            rdy rdata         req addr          instr         pc            vld le rst
        vecs.push_back(mk(0, 0, 32'h0,        1, 32'h0,        0, 32'h0,        32'h0,        32'h0,        0, 0, 0)); // BOOT
        vecs.push_back(mk(0, 0, 32'h0,        1, 32'h0,        1, 32'h0,        32'h0,        32'h0,        1, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 32'h4,        1, 32'h4,        32'h4,        32'h4,        1, 1, 0));
        vecs.push_back(mk(1, 0, 32'h0,        1, 32'h8,        1, 32'h8,        32'h8,        32'h8,        1, 0, 0)); // -> HOLD
        vecs.push_back(mk(1, 0, 32'h0,        1, D,            0, 32'h8,        32'h8,        32'h8,        1, 0, 0));
        vecs.push_back(mk(1, 0, 32'h0,        1, D,            0, 32'h8,        32'h8,        32'h8,        1, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        1, D,            0, 32'h8,        32'h8,        32'h8,        1, 1, 0)); // release
        vecs.push_back(mk(0, 0, 32'h0,        0, D,            1, 32'hC,        32'h0,        32'hC,        0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 32'hC,        1, 32'hC,        32'hC,        32'hC,        1, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, D,            1, 32'h10,       32'h0,        32'h10,       0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h103,      0, D,            1, 32'h10,       32'h0,        32'h10,       0, 0, 1)); // -> DROP
        vecs.push_back(mk(0, 0, 32'h0,        0, D,            1, 32'h10,       32'h0,        32'h10,       0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, D,            1, 32'h10,       32'h0,        32'h10,       0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 32'h10,       1, 32'h10,       32'h0,        32'h10,       0, 0, 0)); // dropped
        vecs.push_back(mk(0, 0, 32'h0,        1, 32'h100,      1, 32'h100,      32'h100,      32'h100,      1, 1, 0));
        vecs.push_back(mk(0, 1, 32'h20,       1, 32'h104,      1, 32'h104,      32'h0,        32'h104,      0, 0, 1));
        vecs.push_back(mk(0, 1, 32'h40,       1, 32'h20,       1, 32'h20,       32'h0,        32'h20,       0, 0, 1)); // redirect+ready
        vecs.push_back(mk(0, 1, 32'h80,       0, D,            1, 32'h40,       32'h0,        32'h40,       0, 0, 1)); // -> DROP
        vecs.push_back(mk(0, 1, 32'h90,       0, D,            1, 32'h40,       32'h0,        32'h40,       0, 0, 1)); // latest wins
        vecs.push_back(mk(0, 0, 32'h0,        1, 32'h40,       1, 32'h40,       32'h0,        32'h40,       0, 0, 0));
        vecs.push_back(mk(1, 0, 32'h0,        1, 32'h90,       1, 32'h90,       32'h90,       32'h90,       1, 0, 0)); // -> HOLD
        vecs.push_back(mk(1, 1, 32'h200,      1, D,            0, 32'h90,       32'h0,        32'h90,       0, 0, 1)); // flush wins
        vecs.push_back(mk(0, 0, 32'h0,        1, 32'h200,      1, 32'h200,      32'h200,      32'h200,      1, 1, 0));
        vecs.push_back(mk(1, 0, 32'h0,        0, D,            1, 32'h204,      32'h0,        32'h204,      0, 0, 0)); // stall ignored
        vecs.push_back(mk(0, 1, 32'hFFFFFFFF, 1, 32'h204,      1, 32'h204,      32'h0,        32'h204,      0, 0, 1));
        vecs.push_back(mk(0, 0, 32'h0,        1, 32'hFFFFFFFC, 1, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'hFFFFFFFC, 1, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 32'h0,        1, 32'h0,        32'h0,        32'h0,        1, 1, 0)); // wrapped
        vecs.push_back(mk(0, 1, 32'h300,      0, D,            1, 32'h4,        32'h0,        32'h4,        0, 0, 1)); // -> DROP
        vecs.push_back(mk(0, 1, 32'h404,      1, D,            1, 32'h4,        32'h0,        32'h4,        0, 0, 1)); // same-cycle target
        vecs.push_back(mk(0, 0, 32'h0,        0, D,            1, 32'h404,      32'h0,        32'h404,      0, 0, 0));

        // Reset held: outputs in their reset values.
        repeat (2) @(posedge clk);
        #2;
        chk_reset_outputs("in_reset");

        // Release mid-cycle so the first table row observes BOOT.
        @(posedge clk);
        #2;
        Reset = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Asynchronous reset between edges while a request is waiting.
        @(posedge clk);
        #2;
        Reset = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        @(posedge clk);
        #2;
        chk_reset_outputs("async_rst_held");

        // Restart from RESET_PC.
        stall_in       = 1'b0;
        redirect_valid = 1'b0;
        imem_ready     = 1'b1;
        imem_rdata     = 32'h0;
        @(posedge clk);
        #2;
        Reset = 1'b1;
        apply(mk(0, 0, 32'h0, 1, 32'h0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0), "restart_boot");
        apply(mk(0, 0, 32'h0, 1, 32'h0, 1, 32'h0, 32'h0, 32'h0, 1, 1, 0), "restart_req");
        apply(mk(0, 0, 32'h0, 1, 32'h4, 1, 32'h4, 32'h4, 32'h4, 1, 1, 0), "restart_seq");

        // Redirect arriving in BOOT, with low address bits to be cleared.
        @(posedge clk);
        #2;
        Reset = 1'b0;
        @(posedge clk);
        #2;
        Reset = 1'b1;
        apply(mk(0, 1, 32'h57, 0, D, 0, 32'h0, 32'h0, 32'h0, 0, 0, 1), "boot_redir");
        apply(mk(0, 0, 32'h0, 0, D, 1, 32'h54, 32'h0, 32'h54, 0, 0, 0), "boot_redir_req");
        apply(mk(0, 0, 32'h0, 1, 32'hABCD, 1, 32'h54, 32'hABCD, 32'h54, 1, 1, 0), "boot_redir_fetch");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guard against a hung simulation.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register. It owns the program counter and runs a valid/ready request handshake to instruction memory. It presents each fetched word, with its PC, to IF/ID together with the load-enable and flush controls that register consumes. It also absorbs hazard-unit stalls and EX-stage redirects (branch, JAL, JALR).

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0
PC_STEP, 4, sequential PC increment in bytes

Ports:
clk  input  1  clock; all state updates on rising edge
Reset  input  1  asynchronous, active-low reset (0 = reset)
stall_in  input  1  hazard unit: hold IF/ID contents
redirect_valid  input  1  EX stage: control transfer taken this cycle
redirect_target  input  32  new PC; bits [1:0] ignored and treated as 00
imem_req  output  1  instruction-memory request valid
imem_addr  output  32  request address (word aligned)
imem_ready  input  1  memory returns imem_rdata this cycle for the current request
imem_rdata  input  32  instruction word
fetch_instr  output  32  instruction to IF/ID (drives Instuction_Mem_OUT)
fetch_pc  output  32  PC of fetch_instr
fetch_valid  output  1  fetch_instr/fetch_pc hold a real instruction this cycle
IF_ID_LE  output  1  load enable for IF/ID
IF_ID_Reset  output  1  flush for IF/ID (active-high, as IF/ID expects)

Behaviour:
- Registers: pc[31:0], redir_pc[31:0], buf_instr[31:0], buf_pc[31:0], state ∈ {BOOT, REQ, HOLD, DROP}.
- Reset=0, applied asynchronously: pc=RESET_PC, state=BOOT, buffers=0.
  - Outputs while in reset: imem_req=0, IF_ID_LE=0, fetch_valid=0, fetch_instr=0, fetch_pc=0, IF_ID_Reset=1.
- Reset mid-operation drops any outstanding request immediately; memory must tolerate the dropped request.
- Handshake: once imem_req=1, imem_addr is held stable until a cycle with imem_ready=1. imem_ready is ignored while imem_req=0. imem_addr = pc in all states.
- Priority of inputs: redirect_valid > stall_in > sequential fetch.
- IF_ID_Reset = redirect_valid (combinational), or 1 while in reset.
- IF_ID_LE is never 1 in the same cycle as IF_ID_Reset.
- BOOT: imem_req=0, LE=0. Next cycle → REQ. A redirect in BOOT loads pc=target.
- REQ: imem_req=1.
  - imem_ready=0, no redirect: stay in REQ; stall_in has no effect.
  - imem_ready=0 with redirect: redir_pc<=target; → DROP.
  - imem_ready=1 with redirect: word discarded; pc<=target; stay in REQ; LE=0.
  - imem_ready=1, no redirect, stall_in=0: fetch_instr=imem_rdata, fetch_pc=pc, fetch_valid=1, LE=1; pc<=pc+PC_STEP; stay in REQ.
  - imem_ready=1, no redirect, stall_in=1: fetch_valid=1, LE=0; buf_instr<=imem_rdata, buf_pc<=pc; → HOLD.
- HOLD: imem_req=0; fetch_instr=buf_instr, fetch_pc=buf_pc, fetch_valid=1.
  - stall_in=1: stay in HOLD, LE=0.
  - stall_in=0: LE=1; pc<=pc+PC_STEP; → REQ.
  - redirect: buffer discarded, LE=0, fetch_valid=0; pc<=target; → REQ.
- DROP: imem_req=1 at the old pc; fetch_valid=0, LE=0.
  - Further redirect: redir_pc<=latest target (latest wins).
  - imem_ready=1: response discarded; pc<=redir_pc, or the same-cycle redirect target if present; → REQ.
- Outside the named cases: fetch_instr=0, fetch_pc=pc, fetch_valid=0, LE=0.
- Arithmetic: pc+PC_STEP is modulo 2^32, so 32'hFFFF_FFFC → 32'h0000_0000. Redirect target is stored with [1:0]=00.
- Throughput: one instruction per cycle when imem_ready is held at 1 and there are no stalls or redirects.
- First IF_ID_LE occurs no earlier than the second rising edge after Reset deasserts.

Test Plan:
- Reset release, imem_ready=1 constant, instructions = address value → imem_addr 0,4,8,C on consecutive cycles; LE=1 each cycle from REQ entry; fetch_pc matches fetch_instr.
- Zero-wait fetch at pc=8, then stall_in=1 for 3 cycles → enter HOLD; imem_req=0; fetch_instr stays 0x8 with LE=0. Release → LE=1 for one cycle, then the next request goes to addr 0xC.
- imem_ready=0 for 4 cycles at pc=0x10, redirect to 0x103 on cycle 2 → imem_addr stays 0x10 until ready; response dropped (LE=0); next request at 0x100.
- Redirect to 0x40 coincident with imem_ready at pc=0x20 → IF_ID_Reset=1, LE=0, next imem_addr=0x40. Two redirects during DROP (0x80 then 0x90) → next address 0x90.
- Redirect and stall_in both asserted in HOLD → flush wins: IF_ID_Reset=1, LE=0, then REQ at the target.
- Reset asserted asynchronously mid-wait (between edges) → imem_req=0, IF_ID_Reset=1, fetch_valid=0 immediately. After release, fetch restarts at RESET_PC. pc=0xFFFF_FFFC with zero wait → next addr 0x0.
